// File: rtl/nios2_print_sequencer_if.sv
// Avalon-MM slave bus, byte output stream and interrupt for nios2_print_sequencer.
// slave = sequencer side, master = CPU / consumer side.
interface nios2_print_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        out_valid;
  logic        out_ready;
  logic        irq;

  modport slave (
    input  address, chipselect, write_n, read_n, writedata, out_ready,
    output readdata, out_port, out_valid, irq
  );

  modport master (
    output address, chipselect, write_n, read_n, writedata, out_ready,
    input  readdata, out_port, out_valid, irq
  );
endinterface

// File: rtl/nios2_print_sequencer.sv
// Byte FIFO behind an Avalon-MM slave, drained onto a valid/ready byte port with a programmable gap.
// Define PRINT_SEQ_IRQ_EN to build the irq_en control bit and the registered interrupt.
module nios2_print_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nios2_print_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
  logic [CW-1:0]          count_q;
  logic                   empty, full, busy;
  logic                   enable_q, irq_en, overflow_q;
  logic [GAP_WIDTH-1:0]   gap_q, gap_cnt_q, gap_cnt_d;
  logic [7:0]             out_port_q;
  logic                   out_vld_q, out_vld_d;
  logic                   wr_en, push_req, push_ok, flush, ovf_clr;
  logic                   pop, load_head, load_next;
  logic [7:0]             cnt8;
  logic [31:0]            rdata;
  logic                   unused_sigs;

  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign push_req   = wr_en & (bus.address == 2'd0);
  assign ovf_clr    = wr_en & (bus.address == 2'd1) & bus.writedata[3];
  assign flush      = wr_en & (bus.address == 2'd2) & bus.writedata[2];
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign busy       = (state_q != IDLE);
  assign push_ok    = push_req & ~full & ~flush;
  assign rd_ptr_nxt = rd_ptr_q + AW'(1);
  assign cnt8       = 8'(count_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 1'b0;
      gap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en && bus.address == 2'd2) enable_q <= bus.writedata[0];
      if (wr_en && bus.address == 2'd3) gap_q <= bus.writedata[GAP_WIDTH-1:0];
      // A push into a full FIFO is lost even when the head pops this cycle.
      if (push_req && full) overflow_q <= 1'b1;
      else if (ovf_clr)     overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= bus.writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_nxt;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    out_vld_d = out_vld_q;
    pop       = 1'b0;
    load_head = 1'b0;
    load_next = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      out_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_q && !empty) begin
            state_d   = PRESENT;
            out_vld_d = 1'b1;
            load_head = 1'b1;
          end
        end
        PRESENT: begin
          if (bus.out_ready) begin
            pop = 1'b1;
            if (gap_q != '0) begin
              state_d   = GAP;
              out_vld_d = 1'b0;
              gap_cnt_d = gap_q;
            end else if (enable_q && count_q > CW'(1)) begin
              load_next = 1'b1;
            end else begin
              state_d   = IDLE;
              out_vld_d = 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_WIDTH'(1)) begin
            if (enable_q && !empty) begin
              state_d   = PRESENT;
              out_vld_d = 1'b1;
              load_head = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          out_vld_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_port_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      out_vld_q <= out_vld_d;
      // Back-to-back reads the entry behind the head being popped this cycle.
      if (load_head)      out_port_q <= mem[rd_ptr_q];
      else if (load_next) out_port_q <= mem[rd_ptr_nxt];
    end
  end

`ifdef PRINT_SEQ_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && bus.address == 2'd2) irq_en <= bus.writedata[1];
      irq_q <= irq_en & empty & ~busy;
    end
  end

  assign bus.irq = irq_q;
`else
  assign irq_en  = 1'b0;
  assign bus.irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (bus.address)
      2'd0:    rdata = {24'b0, out_port_q};
      2'd1:    rdata = {16'b0, cnt8, 4'b0, overflow_q, busy, full, empty};
      2'd2:    rdata = {30'b0, irq_en, enable_q};
      default: rdata = 32'(gap_q);
    endcase
  end

  assign bus.readdata  = rdata;
  assign bus.out_port  = out_port_q;
  assign bus.out_valid = out_vld_q;

  // Reads have no side effects, so read_n and the upper write bits are never decoded.
  assign unused_sigs = ^{bus.read_n, bus.writedata};
endmodule

// File: tb/tb_nios2_print_sequencer.sv
// Scoreboard bench for nios2_print_sequencer: a byte queue models the FIFO, a monitor checks every handshake.
module tb_nios2_print_sequencer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  nios2_print_sequencer_if bus ();

  nios2_print_sequencer #(.FIFO_DEPTH(DEPTH), .GAP_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q[$];
  bit         model_ovf = 1'b0;
  bit         m_en = 1'b0;
  logic [7:0] m_gap = 8'h00;
  bit         flush_now = 1'b0;
  int         hs_gap_q[$];
  int         low_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected STATUS from the queue model: count, overflow, busy, full, empty.
  function automatic logic [31:0] status_exp(input bit busy);
    logic [7:0] n;
    n = 8'(model_q.size());
    return {16'b0, n, 4'b0, model_ovf, busy, model_q.size() == DEPTH, model_q.size() == 0};
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    case (a)
      2'd0: if (model_q.size() < DEPTH) model_q.push_back(d[7:0]); else model_ovf = 1'b1;
      2'd1: if (d[3]) model_ovf = 1'b0;
      2'd2: begin
        m_en = d[0];
        if (d[2]) begin
          model_q.delete();
          flush_now = 1'b1;
        end
      end
      default: m_gap = d[7:0];
    endcase
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    flush_now      = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    #1 d = bus.readdata;
    tick();
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((model_q.size() != 0 || bus.out_valid) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d bytes left, required 0", name, model_q.size());
    end
    repeat (12) tick();
  endtask

  // Monitor: a handshake happens at the next rising edge when valid&ready are seen here.
  initial begin
    logic [7:0] prev_port;
    logic [7:0] exp;
    bit prev_hold;
    prev_hold = 1'b0;
    prev_port = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_hold = 1'b0;
        low_run   = 0;
      end else if (bus.out_valid && !flush_now) begin
        if (prev_hold) chk("hold_stable", {24'b0, bus.out_port}, {24'b0, prev_port});
        if (bus.out_ready) begin
          if (model_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_byte: got %h required no handshake", bus.out_port);
          end else begin
            exp = model_q.pop_front();
            chk("out_byte", {24'b0, bus.out_port}, {24'b0, exp});
          end
          hs_gap_q.push_back(low_run);
          low_run   = 0;
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_port = bus.out_port;
        end
      end else begin
        prev_hold = 1'b0;
        if (!bus.out_valid) low_run++;
      end
    end
  end

  initial begin
    logic [31:0] d;
    int r;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
    bus.writedata  = 32'h0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    rd(2'd1, d); chk("rst_status", d, 32'h0000_0001);
    rd(2'd2, d); chk("rst_control", d, 32'h0);
    rd(2'd3, d); chk("rst_gap", d, 32'h0);
    rd(2'd0, d); chk("rst_data", d, 32'h0);

    // Back-to-back with gap 0
    bus.out_ready = 1'b1;
    hs_gap_q.delete();
    wr(2'd0, 32'h41); wr(2'd0, 32'h42); wr(2'd0, 32'h43);
    wr(2'd3, 32'h0);
    wr(2'd2, 32'h1);
    wait_drain("b2b_drain");
    chk("b2b_count", hs_gap_q.size(), 32'd3);
    if (hs_gap_q.size() == 3) begin
      chk("b2b_gap1", hs_gap_q[1], 32'd0);
      chk("b2b_gap2", hs_gap_q[2], 32'd0);
    end
    chk("b2b_valid", {31'b0, bus.out_valid}, 32'h0);
    rd(2'd1, d); chk("b2b_status", d, 32'h0000_0001);
    rd(2'd0, d); chk("b2b_data", d, 32'h43);

    // Programmed gap of 3
    wr(2'd3, 32'h3);
    rd(2'd3, d); chk("gap_readback", d, 32'h3);
    hs_gap_q.delete();
    wr(2'd0, 32'h10); wr(2'd0, 32'h20);
    wait_drain("gap_drain");
    chk("gap_hs_count", hs_gap_q.size(), 32'd2);
    if (hs_gap_q.size() == 2) chk("gap_len", hs_gap_q[1], 32'd3);

    // Stall with ready low, then disable before the handshake
    wr(2'd3, 32'h0);
    bus.out_ready = 1'b0;
    hs_gap_q.delete();
    wr(2'd0, 32'h55); wr(2'd0, 32'h66); wr(2'd0, 32'h77);
    for (int i = 0; i < 10; i++) begin
      chk("stall_out", {23'b0, bus.out_valid, bus.out_port}, {23'b0, 1'b1, 8'h55});
      tick();
    end
    wr(2'd2, 32'h0);
    chk("stall_after_dis", {23'b0, bus.out_valid, bus.out_port}, {23'b0, 1'b1, 8'h55});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("stall_hs_once", hs_gap_q.size(), 32'd1);
    chk("stall_valid", {31'b0, bus.out_valid}, 32'h0);
    rd(2'd1, d); chk("stall_status", d, status_exp(1'b0));

    // Overflow, overflow clear, flush
    wr(2'd2, 32'h4);
    for (int i = 0; i <= DEPTH; i++) wr(2'd0, 32'(8'hA0 + i));
    rd(2'd1, d); chk("ovf_status", d, 32'h0000_100A);
    chk("ovf_model", d, status_exp(1'b0));
    wr(2'd1, 32'h8);
    rd(2'd1, d); chk("ovf_clear", d, 32'h0000_1002);
    wr(2'd2, 32'h4);
    rd(2'd1, d); chk("flush_status", d, 32'h0000_0001);
    rd(2'd2, d); chk("flush_ctrl", d, 32'h0);

`ifdef PRINT_SEQ_IRQ_EN
    bus.out_ready = 1'b1;
    wr(2'd2, 32'h3);
    tick();
    chk("irq_idle", {31'b0, bus.irq}, 32'h1);
    wr(2'd0, 32'h99);
    tick();
    chk("irq_busy", {31'b0, bus.irq}, 32'h0);
    wait_drain("irq_drain");
    chk("irq_after", {31'b0, bus.irq}, 32'h1);
    wr(2'd2, 32'h1);
    tick();
    tick();
    chk("irq_masked", {31'b0, bus.irq}, 32'h0);
`else
    wr(2'd2, 32'h2);
    rd(2'd2, d); chk("ctrl_irq_en_absent", d, 32'h0);
    repeat (3) tick();
    chk("irq_tied", {31'b0, bus.irq}, 32'h0);
`endif

    // Randomized traffic against the queue model
    wr(2'd2, 32'h1);
    for (int c = 0; c < 600; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      if (r <= 5)       wr(2'd0, 32'($urandom_range(0, 255)));
      else if (r == 6)  wr(2'd3, 32'($urandom_range(0, 3)));
      else if (r == 7)  wr(2'd2, {31'b0, ~m_en});
      else if (r == 8 && $urandom_range(0, 3) == 0) wr(2'd2, {29'b0, 1'b1, 1'b0, m_en});
      else if (r == 9)  wr(2'd1, 32'h8);
      else tick();
    end
    wr(2'd2, 32'h1);
    bus.out_ready = 1'b1;
    wait_drain("rand_drain");
    rd(2'd1, d); chk("rand_status", d, status_exp(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
